// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage ahead of the decoder.
// Holds the PC, fetches one 16-bit word at a time over a req/rvalid handshake,
// presents it on Iout, waits for ex_done, then picks the next PC from the
// decoder's branch/halt outputs and the ALU flags.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start                   pulse that leaves IDLE and begins fetching
//   imem_req/imem_addr      fetch request and byte address (always equals pc)
//   imem_rdata/imem_rvalid  returned instruction word and its strobe
//   Iout/ir_valid           instruction register to the decoder and its valid
//   ex_done                 execute finished the instruction on Iout
//   BS/OFF/HALT             branch select, signed byte offset, halt (decoder)
//   Z/N                     ALU zero/negative flags
//   pc/halted/instret       current PC, halted status, retired count
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_rvalid,
    output logic [15:0] Iout,
    output logic        ir_valid,
    input  logic        ex_done,
    input  logic [2:0]  BS,
    input  logic [7:0]  OFF,
    input  logic        HALT,
    input  logic        Z,
    input  logic        N,
    output logic [15:0] pc,
    output logic        halted,
    output logic [15:0] instret
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        ISSUE,
        HALTED
    } state_t;

    state_t      state;
    logic        taken;
    logic [15:0] seq_pc;
    logic [15:0] branch_pc;

    // BS=1xx never branches
    always_comb begin
        taken = 1'b0;
        case (BS)
            3'b000:  taken = Z;
            3'b001:  taken = ~Z;
            3'b010:  taken = N;
            3'b011:  taken = ~N;
            default: taken = 1'b0;
        endcase
    end

    assign seq_pc    = pc + 16'd2;
    assign branch_pc = seq_pc + {{8{OFF[7]}}, OFF};
    assign imem_addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            Iout     <= '0;
            ir_valid <= 1'b0;
            imem_req <= 1'b0;
            halted   <= 1'b0;
            instret  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    imem_req <= 1'b0;
                    if (start) begin
                        state    <= FETCH;
                        imem_req <= 1'b1;
                    end
                end
                FETCH: begin
                    if (imem_rvalid) begin
                        Iout     <= imem_rdata;
                        ir_valid <= 1'b1;
                        imem_req <= 1'b0;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (ex_done) begin
                        instret  <= instret + 16'd1;
                        ir_valid <= 1'b0;
                        // HALT wins over any taken branch and freezes pc
                        if (HALT) begin
                            halted <= 1'b1;
                            state  <= HALTED;
                        end else begin
                            pc       <= taken ? branch_pc : seq_pc;
                            imem_req <= 1'b1;
                            state    <= FETCH;
                        end
                    end
                end
                HALTED: begin
                    halted   <= 1'b1;
                    imem_req <= 1'b0;
                    ir_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized scoreboard bench for fetch_unit.
// The stimulus process plays instruction memory and execute; each returned word
// and each retirement outcome is pushed into a queue, and a negedge monitor pops
// and compares whenever ir_valid rises (new instruction) or falls (retirement).
module tb_fetch_unit;

    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_rvalid;
    logic [15:0] Iout;
    logic        ir_valid;
    logic        ex_done;
    logic [2:0]  BS;
    logic [7:0]  OFF;
    logic        HALT;
    logic        Z;
    logic        N;
    logic [15:0] pc;
    logic        halted;
    logic [15:0] instret;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid),
        .Iout(Iout), .ir_valid(ir_valid), .ex_done(ex_done),
        .BS(BS), .OFF(OFF), .HALT(HALT), .Z(Z), .N(N),
        .pc(pc), .halted(halted), .instret(instret)
    );

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct {
        logic [15:0] pc;
        logic [15:0] instret;
        logic        halted;
    } retire_t;

    logic [15:0] fetch_q[$];
    retire_t     retire_q[$];

    // architectural reference state
    logic [15:0] m_pc;
    logic [15:0] m_instret;
    logic        m_halted;

    function automatic logic [15:0] ref_next_pc(input logic [15:0] p, input logic [2:0] bs,
                                                input logic [7:0] off, input logic z, input logic n);
        bit take;
        int disp;
        take = (bs == 3'd0 && z) || (bs == 3'd1 && !z) || (bs == 3'd2 && n) || (bs == 3'd3 && !n);
        disp = int'($signed(off));
        return 16'(int'(p) + 2 + (take ? disp : 0));
    endfunction

    // monitor
    logic        prev_v = 1'b0;
    logic [15:0] cur_ir = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (ir_valid && !prev_v) begin
                if (fetch_q.size() == 0) check("unexpected_ir_valid", 16'(ir_valid), 16'h0);
                else begin
                    cur_ir = fetch_q.pop_front();
                    check("Iout", Iout, cur_ir);
                end
            end else if (ir_valid) begin
                check("Iout_hold", Iout, cur_ir);
            end
            if (!ir_valid && prev_v) begin
                if (retire_q.size() == 0) check("unexpected_retire", 16'(ir_valid), 16'h1);
                else begin
                    retire_t r;
                    r = retire_q.pop_front();
                    check("retire_pc", pc, r.pc);
                    check("retire_instret", instret, r.instret);
                    check("retire_halted", 16'(halted), 16'(r.halted));
                end
            end
            prev_v = ir_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_pc      = RESET_PC;
        m_instret = '0;
        m_halted  = 1'b0;
        fetch_q.delete();
        retire_q.delete();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pc"},       pc, RESET_PC);
        check({tag, "_Iout"},     Iout, 16'h0000);
        check({tag, "_ir_valid"}, 16'(ir_valid), 16'h0);
        check({tag, "_imem_req"}, 16'(imem_req), 16'h0);
        check({tag, "_halted"},   16'(halted), 16'h0);
        check({tag, "_instret"},  instret, 16'h0000);
    endtask

    task automatic fetch(input int unsigned lat, input logic [15:0] data, input bit spur_ex);
        int unsigned guard = 0;
        while (!imem_req && guard < 20) begin
            tick();
            guard++;
        end
        check("req_seen", 16'(imem_req), 16'h1);
        for (int unsigned i = 1; i < lat; i++) begin
            check("req_hold", 16'(imem_req), 16'h1);
            check("addr_hold", imem_addr, m_pc);
            if (spur_ex && i == 1) ex_done = 1'b1;
            tick();
            ex_done = 1'b0;
            check("pc_in_fetch", pc, m_pc);
            check("instret_in_fetch", instret, m_instret);
        end
        check("req_last", 16'(imem_req), 16'h1);
        check("addr_last", imem_addr, m_pc);
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        fetch_q.push_back(data);
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = 16'($urandom);
        check("ir_valid_after_rvalid", 16'(ir_valid), 16'h1);
        check("req_drop", 16'(imem_req), 16'h0);
    endtask

    task automatic execute(input int unsigned wait_c, input logic [2:0] bs, input logic [7:0] off,
                           input logic halt, input logic z, input logic n,
                           input bit with_start, input bit spur_rv);
        retire_t r;
        for (int unsigned i = 0; i < wait_c; i++) begin
            if (spur_rv && i == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = 16'($urandom);
            end
            tick();
            imem_rvalid = 1'b0;
        end
        ex_done = 1'b1;
        BS = bs; OFF = off; HALT = halt; Z = z; N = n;
        start = with_start;
        m_instret = m_instret + 16'd1;
        if (halt) m_halted = 1'b1;
        else      m_pc = ref_next_pc(m_pc, bs, off, z, n);
        r.pc = m_pc; r.instret = m_instret; r.halted = m_halted;
        retire_q.push_back(r);
        tick();
        ex_done = 1'b0;
        start   = 1'b0;
        HALT    = 1'b0;
        BS  = 3'($urandom);
        OFF = 8'($urandom);
        Z   = 1'($urandom);
        N   = 1'($urandom);
    endtask

    // directed branch table: bs, off, z, n, resulting pc
    logic [2:0]  d_bs [7] = '{3'b000, 3'b000, 3'b001, 3'b000, 3'b011, 3'b010, 3'b100};
    logic [7:0]  d_off[7] = '{8'h0C,  8'h0A,  8'hF2,  8'h0A,  8'hF0,  8'hF8,  8'h00};
    logic        d_z  [7] = '{1'b1,   1'b1,   1'b0,   1'b0,   1'b0,   1'b0,   1'b0};
    logic        d_n  [7] = '{1'b0,   1'b0,   1'b0,   1'b0,   1'b0,   1'b1,   1'b0};
    logic [15:0] d_pc [7] = '{16'h0010, 16'h001C, 16'h0010, 16'h0012, 16'h0004, 16'hFFFE, 16'h0000};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        ex_done = 1'b0; BS = '0; OFF = '0; HALT = 1'b0; Z = 1'b0; N = 1'b0;
        model_reset();
        repeat (3) tick();
        check_reset_values("reset");
        rst_n = 1'b1;
        tick();

        // rvalid while IDLE is ignored
        imem_rvalid = 1'b1; imem_rdata = 16'hBEEF;
        tick();
        imem_rvalid = 1'b0;
        check("idle_rvalid_Iout", Iout, 16'h0000);
        check("idle_rvalid_req", 16'(imem_req), 16'h0);
        check("idle_rvalid_ir_valid", 16'(ir_valid), 16'h0);

        start = 1'b1;
        tick();
        start = 1'b0;
        fetch(3, 16'h1234, 1'b0);
        execute(1, 3'b100, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("first_pc", pc, 16'h0002);
        check("first_instret", instret, 16'h0001);

        for (int i = 0; i < 7; i++) begin
            fetch($urandom_range(1, 4), 16'($urandom), 1'($urandom));
            execute($urandom_range(0, 3), d_bs[i], d_off[i], 1'b0, d_z[i], d_n[i], 1'b0, 1'($urandom));
            check("directed_pc", pc, d_pc[i]);
        end

        for (int i = 0; i < 80; i++) begin
            fetch($urandom_range(1, 4), 16'($urandom), 1'($urandom));
            execute($urandom_range(0, 3), 3'($urandom), 8'($urandom) & 8'hFE, 1'b0,
                    1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end

        // asynchronous reset in the middle of a fetch
        @(negedge clk);
        #1;
        check("pre_reset_req", 16'(imem_req), 16'h1);
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        model_reset();
        tick();
        rst_n = 1'b1;
        imem_rvalid = 1'b1; imem_rdata = 16'hDEAD;
        tick();
        imem_rvalid = 1'b0;
        check("late_rvalid_Iout", Iout, 16'h0000);
        check("late_rvalid_req", 16'(imem_req), 16'h0);
        check("late_rvalid_ir_valid", 16'(ir_valid), 16'h0);

        start = 1'b1;
        tick();
        start = 1'b0;
        fetch(2, 16'h5A5A, 1'b0);
        execute(0, 3'b111, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("post_reset_pc", pc, 16'h0002);

        // HALT takes priority over a taken branch
        fetch(1, 16'hF00D, 1'b0);
        execute(1, 3'b000, 8'h10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("halt_halted", 16'(halted), 16'h1);
        check("halt_pc", pc, 16'h0002);
        check("halt_instret", instret, 16'h0002);
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            start = 1'b0;
            check("halted_req", 16'(imem_req), 16'h0);
            check("halted_ir_valid", 16'(ir_valid), 16'h0);
            check("halted_stays", 16'(halted), 16'h1);
            check("halted_pc", pc, 16'h0002);
        end

        @(negedge clk);
        #1;
        check("fetch_q_drained", 16'(fetch_q.size()), 16'h0);
        check("retire_q_drained", 16'(retire_q.size()), 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
